// File: rtl/nes_pal_pkg.sv
// Shared constants, entry type and controller state encoding for the NES
// custom palette loader.
package nes_pal_pkg;

  localparam int PAL_ENTRIES   = 64;
  localparam int PAL_IDX_W     = 6;
  localparam int PAL_BYTES_555 = 128;
  localparam int PAL_BYTES_888 = 192;

  // {B[14:10], G[9:5], R[4:0]}
  typedef logic [14:0] pal_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } pal_state_t;

endpackage

// File: rtl/nes_pal_ram.sv
// 64x15 single-port palette RAM with a registered, enable-held read port.
// Shaped so synthesis can map the array onto a block RAM.
module nes_pal_ram
  import nes_pal_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [PAL_IDX_W-1:0] addr,
  input  pal_entry_t           wdata,
  output pal_entry_t           rdata
);

  pal_entry_t mem [PAL_ENTRIES];

  // NOTE: the array has no reset on purpose; a reset branch would stop it
  // mapping to block RAM, and the palette must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

  // The output register holds its value between reads; only it is cleared.
  always_ff @(posedge clk) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/nes_palette_ctrl.sv
// Custom palette controller: arbitrates the palette RAM between pixel reads
// and the HPS byte download, validates each load. Optional macro: PAL_RGB24_EN.
module nes_palette_ctrl
  import nes_pal_pkg::*;
#(
  parameter int ENTRIES = PAL_ENTRIES,
`ifdef PAL_RGB24_EN
  parameter int BYTES_PER_ENTRY = PAL_BYTES_888 / PAL_ENTRIES
`else
  parameter int BYTES_PER_ENTRY = PAL_BYTES_555 / PAL_ENTRIES
`endif
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        pal_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        rd_ce,
  input  logic [5:0]  rd_color,
  output logic [14:0] rd_pixel,
  output logic        pal_valid,
  output logic        load_error,
  output logic [6:0]  entries_loaded
);

  localparam int FILE_BYTES = ENTRIES * BYTES_PER_ENTRY;

  pal_state_t             state;
  logic                   dl_q, dl_rise, dl_fall;
  logic                   buf_full;
  pal_entry_t             buf_data;
  logic [PAL_IDX_W-1:0]   buf_idx;
  logic [7:0]             expected, exp_now;
  logic                   start, loading, in_range, overrun, accept, seq_err;
  logic                   drain, commit_ok;
  logic                   entry_done;
  pal_entry_t             entry_data;
  logic [PAL_IDX_W-1:0]   entry_idx;

  assign dl_rise = pal_download & ~dl_q;
  assign dl_fall = ~pal_download & dl_q;

  // A byte arriving with the download rise already belongs to the new load.
  assign start    = (state == IDLE) && dl_rise;
  assign loading  = start || (state == LOAD);
  assign in_range = int'(ioctl_addr) < FILE_BYTES;
  assign overrun  = loading && ioctl_wr && ioctl_wait;
  assign accept   = loading && ioctl_wr && !ioctl_wait && in_range;
  assign exp_now  = start ? 8'd0 : expected;
  assign seq_err  = accept && (ioctl_addr != exp_now);

  // Pixel reads own the port; a buffered entry lands on the next free cycle.
  assign drain      = buf_full && !rd_ce;
  assign ioctl_wait = buf_full;
  assign commit_ok  = (entries_loaded == 7'(ENTRIES)) && !load_error;

`ifndef PAL_RGB24_EN
  logic [7:0] lo_byte;

  assign entry_done = accept && ioctl_addr[0];
  assign entry_data = {ioctl_dout[6:0], lo_byte};
  assign entry_idx  = ioctl_addr[6:1];

  always_ff @(posedge clk) begin
    if (reset)                         lo_byte <= '0;
    else if (accept && !ioctl_addr[0]) lo_byte <= ioctl_dout;
  end
`else
  logic [1:0]           phase, phase_now;
  logic [4:0]           r_hi, g_hi;
  logic [PAL_IDX_W-1:0] ent_cnt, ent_now;

  // Entry position comes from our own counters, not from the byte address.
  assign phase_now  = start ? 2'd0 : phase;
  assign ent_now    = start ? '0 : ent_cnt;
  assign entry_done = accept && (phase_now == 2'd2);
  assign entry_data = {ioctl_dout[7:3], g_hi, r_hi};
  assign entry_idx  = ent_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= '0;
      ent_cnt <= '0;
      r_hi    <= '0;
      g_hi    <= '0;
    end else if (accept) begin
      case (phase_now)
        2'd0: begin
          r_hi  <= ioctl_dout[7:3];
          phase <= 2'd1;
        end
        2'd1: begin
          g_hi  <= ioctl_dout[7:3];
          phase <= 2'd2;
        end
        default: begin
          phase   <= 2'd0;
          ent_cnt <= ent_now + 1'b1;
        end
      endcase
    end else if (start) begin
      phase   <= '0;
      ent_cnt <= '0;
    end
  end
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      dl_q           <= 1'b0;
      buf_full       <= 1'b0;
      buf_data       <= '0;
      buf_idx        <= '0;
      expected       <= '0;
      entries_loaded <= '0;
      pal_valid      <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      dl_q <= pal_download;

      // A new entry can never complete while the buffer is full: ioctl_wait
      // is high for that whole time, so any such byte is dropped.
      if (entry_done) begin
        buf_full <= 1'b1;
        buf_data <= entry_data;
        buf_idx  <= entry_idx;
      end else if (drain) begin
        buf_full <= 1'b0;
      end

      if (accept)     expected <= exp_now + 8'd1;
      else if (start) expected <= '0;

      if (start)
        entries_loaded <= '0;
      else if (drain && entries_loaded != 7'(ENTRIES))
        entries_loaded <= entries_loaded + 7'd1;

      if (overrun || seq_err || (state == COMMIT && !commit_ok))
        load_error <= 1'b1;
      else if (start)
        load_error <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            pal_valid <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD:   if (dl_fall) state <= DRAIN;
        DRAIN:  if (!buf_full) state <= COMMIT;
        COMMIT: begin
          pal_valid <= commit_ok;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  nes_pal_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .rd_en (rd_ce),
    .wr_en (drain),
    .addr  (rd_ce ? rd_color : buf_idx),
    .wdata (buf_data),
    .rdata (rd_pixel)
  );

endmodule
